// File: rtl/matrix_result_sink.sv
// Result buffer between a matrix multiplier and a ready/valid consumer.
// Collects up to max_size*max_size words for a job, then drains them row-major with row/col tags.
module matrix_result_sink #(
    parameter int unsigned max_size = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         sizes,
    input  logic               wen,
    input  logic signed [31:0] wdata,
    input  logic               finish,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [2:0]         out_row,
    output logic [2:0]         out_col,
    output logic               out_last,
    output logic               done,
    output logic               err_ovf,
    output logic               err_cnt,
    output logic [1:0]         state
);

    localparam int unsigned DEPTH = max_size * max_size;
    localparam int unsigned PW    = $clog2(DEPTH + 1);
    localparam logic [3:0]  MAX_N = 4'(max_size);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  exp_q, exp_d;
    logic [3:0]     n_q, n_d;
    logic           out_valid_q, out_valid_d;
    logic [31:0]    out_data_q, out_data_d;
    logic [2:0]     out_row_q, out_row_d;
    logic [2:0]     out_col_q, out_col_d;
    logic           out_last_q, out_last_d;
    logic           done_q, done_d;
    logic           err_ovf_q, err_ovf_d;
    logic           err_cnt_q, err_cnt_d;

    logic [31:0]    mem [DEPTH];
    logic           mem_we;
    logic [PW-1:0]  mem_waddr;
    logic [31:0]    mem_wdata;

    logic [3:0]     n_in;
    logic [PW-1:0]  exp_in;
    logic [PW-1:0]  wr_next;
    logic [PW-1:0]  rd_next;

    always_comb begin
        n_in   = (sizes > MAX_N) ? MAX_N : sizes;
        exp_in = PW'(n_in) * PW'(n_in);
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        n_d         = n_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        err_ovf_d   = err_ovf_q;
        err_cnt_d   = err_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        mem_wdata   = wdata;
        wr_next     = wr_ptr_q;
        rd_next     = rd_ptr_q + PW'(1);

        case (state_q)
            IDLE: begin
                n_d   = n_in;
                exp_d = exp_in;
                // finish wins over a coincident wen: an IDLE finish always drains zero words
                if (finish) begin
                    state_d     = DRAIN;
                    cnt_d       = '0;
                    rd_ptr_d    = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (exp_in != '0) err_cnt_d = 1'b1;
                end else if (wen) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wr_ptr_d  = PW'(1);
                    err_ovf_d = 1'b0;
                    err_cnt_d = 1'b0;
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                if (wen) begin
                    if (wr_ptr_q < exp_q) begin
                        mem_we  = 1'b1;
                        wr_next = wr_ptr_q + PW'(1);
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                end
                wr_ptr_d = wr_next;
                if (finish) begin
                    state_d     = DRAIN;
                    cnt_d       = wr_next;
                    rd_ptr_d    = '0;
                    if (wr_next != exp_q) err_cnt_d = 1'b1;
                    out_valid_d = (wr_next != '0);
                    out_data_d  = mem[0];
                    out_row_d   = '0;
                    out_col_d   = '0;
                    out_last_d  = (wr_next == PW'(1));
                end
            end
            DRAIN: begin
                if (wen) err_ovf_d = 1'b1;
                // out_valid low in DRAIN only happens for an empty job
                if (!out_valid_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = DONE;
                        done_d      = 1'b1;
                    end else begin
                        rd_ptr_d   = rd_next;
                        out_data_d = mem[rd_next];
                        if ({1'b0, out_col_q} == n_q - 4'd1) begin
                            out_col_d = '0;
                            out_row_d = out_row_q + 3'd1;
                        end else begin
                            out_col_d = out_col_q + 3'd1;
                        end
                        out_last_d = (rd_next == cnt_q - PW'(1));
                    end
                end
            end
            DONE: begin
                if (wen) err_ovf_d = 1'b1;
                wr_ptr_d = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            n_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_cnt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            n_q         <= n_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_ovf_q   <= err_ovf_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign err_ovf   = err_ovf_q;
    assign err_cnt   = err_cnt_q;
    assign state     = state_q;

endmodule

// File: doc/matrix_result_sink.md
MATRIX_RESULT_SINK -- requirements
Module: matrix_result_sink

Interface
REQ-001 SHALL have parameter max_size, default 6, giving the maximum matrix dimension; the buffer depth is max_size*max_size words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port sizes, input, 4 bits: matrix dimension N of the current job.
REQ-005 SHALL have port wen, input, 1 bit: result-word strobe from the multiplier.
REQ-006 SHALL have port wdata, input, 32 bits, signed: result word, valid when wen=1.
REQ-007 SHALL have port finish, input, 1 bit: one-cycle end-of-job pulse from the multiplier.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts a word.
REQ-010 SHALL have port out_data, output, 32 bits: result word.
REQ-011 SHALL have ports out_row and out_col, output, 3 bits each: row/column index of out_data.
REQ-012 SHALL have port out_last, output, 1 bit: out_data is the final word of the job.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the last word is accepted.
REQ-014 SHALL have ports err_ovf and err_cnt, output, 1 bit each: sticky overflow and count-mismatch flags.
REQ-015 SHALL have port state, output, 2 bits: current FSM state.

Function
REQ-016 SHALL implement FSM states IDLE=0, COLLECT=1, DRAIN=2, DONE=3.
REQ-017 SHALL latch expected count E=N*N every cycle while in IDLE, with N=sizes clamped to max_size when sizes>max_size; sizes=0 gives E=0.
REQ-018 In IDLE, wen=1 SHALL store wdata at address 0, set the write pointer to 1, clear err_ovf/err_cnt and enter COLLECT.
REQ-019 In COLLECT, wen=1 with write pointer<E SHALL store wdata at the write pointer and increment the pointer.
REQ-020 In COLLECT, wen=1 with write pointer>=E SHALL drop the word and set err_ovf.
REQ-021 finish=1 in IDLE or COLLECT SHALL enter DRAIN; if the write pointer != E, err_cnt SHALL be set. Word count for draining SHALL be C = the write pointer, or 0 if finish arrives in IDLE.
REQ-022 wen and finish in the same COLLECT cycle SHALL store the word (REQ-019/020) before C is taken, so C includes that word.
REQ-023 On the edge entering DRAIN with C>0, out_valid SHALL be 1 with out_data=buffer[0], out_row=0, out_col=0.
REQ-024 With C=0, DRAIN SHALL last one cycle with out_valid=0, then enter DONE.
REQ-025 A transfer SHALL occur when out_valid=1 and out_ready=1 at a rising edge; out_data, out_row, out_col and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 After a non-last transfer, the next word SHALL be presented on the following cycle with no bubble; out_col SHALL increment and wrap to 0 at N-1, incrementing out_row.
REQ-027 out_last SHALL be 1 only when presenting word C-1.
REQ-028 A transfer with out_last=1 SHALL clear out_valid and enter DONE.
REQ-029 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-030 wen=1 in DRAIN or DONE SHALL be ignored and set err_ovf; finish=1 in DRAIN or DONE SHALL be ignored.
REQ-031 Stored words SHALL be output unmodified (32-bit signed, no saturation); buffer addressing SHALL be row-major, address=row*N+col.
REQ-032 err_ovf and err_cnt SHALL remain set until cleared per REQ-018 or by reset.

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE, out_valid=0, out_last=0, done=0, err_ovf=0, err_cnt=0, out_data=0, out_row=0, out_col=0 and zero the pointers, including mid-COLLECT or mid-DRAIN; buffer contents need not be cleared.

Verification
REQ-034 sizes=2, wen with wdata 10,-20,30,40, then finish, out_ready=1 -> out_valid on the next cycle; outputs 10(0,0), -20(0,1), 30(1,0), 40(1,1) on consecutive cycles; out_last on 40; done one cycle later; no errors.
REQ-035 sizes=6, 36 words 0..35 with out_ready toggled 1,0 -> all 36 words in order; data held while out_ready=0; out_row=5, out_col=5, out_last=1 on 35.
REQ-036 sizes=2, 5 wen words, then finish -> fifth word dropped; err_ovf=1; 4 words drained; err_cnt=0.
REQ-037 sizes=3, 7 words, then finish coincident with the 7th -> C=7; err_cnt=1; 7 words drained, last at (2,0).
REQ-038 finish in IDLE with sizes=1 -> DRAIN one cycle without out_valid, done pulse, err_cnt=1.
REQ-039 rst=1 during DRAIN after 2 transfers -> outputs zero immediately; a fresh sizes=1 job then completes normally with flags clear.
